imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader upstream of the single-cycle core's instruction memory.
//  - Receives a byte stream over a valid/ready link and packs it into 32-bit words.
//  - Writes the words to consecutive instruction-memory word addresses.
//  - Holds the core in reset until the image is fully loaded (and, optionally, verified).
//  - Frame format: LEN_HI, LEN_LO (16-bit word count, big-endian), then LEN words of
//    4 bytes each (MSB first), then an optional 1-byte checksum.
// PARAMETERS
//  ADDR_W  10  instruction-memory word-address width; capacity is 2**ADDR_W words
//  LEN_W   16  width of the length header; fixed at 16 by the frame format
// PORTS
//  clk          in   1         system clock; single clock domain
//  rst          in   1         synchronous, active-high reset
//  rx_data      in   8         incoming byte
//  rx_valid     in   1         rx_data is valid
//  rx_ready     out  1         loader accepts a byte; transfer = rx_valid & rx_ready
//  imem_we      out  1         one-cycle write strobe to instruction memory
//  imem_addr    out  ADDR_W    word address (equals byte address [ADDR_W+1:2])
//  imem_wdata   out  32        packed word; first received byte lands in [31:24]
//  core_rst     out  1         reset to the core; 1 until load_done
//  load_done    out  1         image loaded; sticky until rst
//  load_err     out  1         framing/length/checksum error; sticky until rst
//  words_loaded out  ADDR_W+1  count of words written so far
// BEHAVIOUR
//  - All outputs are registered. Reset values:
//    rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1,
//    load_done=0, load_err=0, words_loaded=0.
//  - FSM states: S_LEN_HI -> S_LEN_LO -> S_DATA -> [S_CSUM] -> S_DONE; S_ERR.
//  - rx_ready=1 only in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; it is 0 in S_DONE and S_ERR.
//  - The FSM advances only on a handshake. A stalled rx_valid leaves all state unchanged.
//  - Length check, on LEN_LO accept:
//    - LEN > 2**ADDR_W: go to S_ERR; load_err=1 next cycle.
//    - LEN == 0: skip S_DATA (go to S_CSUM or S_DONE).
//  - S_DATA: a 2-bit byte counter shifts bytes into a word register.
//    - On the 4th byte accept: imem_we=1 for exactly one cycle, in the following cycle.
//    - In that strobe cycle, imem_wdata holds the packed word and imem_addr holds the word index.
//    - The word index starts at 0 and increments after each write; it never wraps
//      (bounded by the length check).
//    - words_loaded increments in the same cycle as the strobe.
//    - After LEN words have been accepted, go to S_CSUM or S_DONE.
//  - Back-to-back bytes (rx_valid held high) are accepted every cycle; there are no bubbles.
//  - Entering S_DONE: load_done=1 and core_rst=0 in the cycle after the state is entered.
//    Therefore the final imem_we always precedes the core_rst release by at least one cycle.
//  - S_ERR: core_rst stays 1 and load_err=1. Only rst leaves S_DONE or S_ERR.
//  - rst mid-frame: the partial word is discarded; the FSM returns to S_LEN_HI with all
//    counters cleared. Words already written stay in memory.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//    - A running XOR of all data bytes is kept; it is cleared on rst.
//    - After the last data byte, the FSM enters S_CSUM and accepts one byte.
//    - Byte == XOR: go to S_DONE. Otherwise: go to S_ERR.
//    - LEN==0 expects a checksum byte of 8'h00.
//  Not defined:
//    - No S_CSUM state and no XOR register.
//    - After the last data byte (or LEN_LO when LEN==0), go straight to S_DONE.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - state encoding localparams (S_LEN_HI..S_ERR);
//    - IMEM_ADDR_W=10;
//    - the frame constant LEN_BYTES=2.
//  - One sub-module: byte_word_packer.
//    - Contents: shift register, 2-bit byte counter, word_valid pulse.
//    - Reused later for the data-memory debug path.
//  - Address/length counters and the FSM live in imem_loader.
// TESTING
//  1. Reset: hold rst for 3 cycles.
//     -> core_rst=1, rx_ready=0 during rst; rx_ready=1 on the first cycle after; all else 0.
//  2. Load 2 words, rx_valid always high (00 02 DE AD BE EF 12 34 56 78 [csum]).
//     -> imem_we pulses with addr 0/DEADBEEF and addr 1/12345678.
//     -> words_loaded=2, load_done=1, core_rst=0; no strobes after done.
//  3. Same stream with random rx_valid gaps of 0-5 cycles.
//     -> identical writes; no byte duplicated or dropped.
//  4. LEN=0x0401 (1025 > 1024).
//     -> load_err=1 and rx_ready=0 the cycle after LEN_LO; imem_we never asserted; core_rst=1.
//  5. With IMEM_LOADER_CHECKSUM_EN: 1 word 01020304, checksum byte 0x04 (correct XOR).
//     -> load_done=1. Repeat with 0x05 -> load_err=1, core_rst=1.
//  6. Assert rst after 6 bytes of frame (2).
//     -> FSM restarts; a full resend of frame (2) yields the same writes and load_done=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the boot loader: loader FSM states, default memory width, frame constants.
// The S_CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package mips_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int LEN_BYTES   = 2;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses for one cycle
// after the 4th byte, with word holding the packed value.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  byte_cnt
);

  logic [23:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_vld) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          word       <= {sh, byte_in};
          word_valid <= 1'b1;
        end else begin
          // the next three bytes overwrite all of sh, so no clear is needed
          sh <= {sh[15:0], byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN_HI/LEN_LO + LEN words (+ checksum byte when IMEM_LOADER_CHECKSUM_EN
// is defined), writes instruction memory and holds the core in reset until the image is in.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = LEN_BYTES * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [LEN_W:0]    CAP      = (LEN_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [7:0]        len_hi;
  logic [ADDR_W:0]   len_words;
  logic [LEN_W-1:0]  len_full;
  logic              acc, len_big, last_word;
  logic [1:0]        pk_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign acc       = rx_valid & rx_ready;
  assign len_full  = LEN_W'({len_hi, rx_data});
  assign len_big   = {1'b0, len_full} > CAP;
  assign last_word = (words_loaded + WORD_ONE) == len_words;

  byte_word_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (rx_data),
    .byte_vld   (acc && (state == S_DATA)),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .byte_cnt   (pk_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LEN_HI;
      rx_ready     <= 1'b0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      imem_addr    <= '0;
      len_hi       <= '0;
      len_words    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      // address follows the strobe; length check keeps it in range, saturate as a guard
      if (imem_we && imem_addr != ADDR_MAX) imem_addr <= imem_addr + ADDR_ONE;
      case (state)
        S_LEN_HI: begin
          rx_ready <= 1'b1;
          if (acc) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: if (acc) begin
          if (len_big) begin
            state    <= S_ERR;
            rx_ready <= 1'b0;
            load_err <= 1'b1;
          end else if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CSUM;
`else
            state    <= S_DONE;
            rx_ready <= 1'b0;
`endif
          end else begin
            len_words <= len_full[ADDR_W:0];
            state     <= S_DATA;
          end
        end
        S_DATA: if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
          if (pk_cnt == 2'd3) begin
            words_loaded <= words_loaded + WORD_ONE;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              rx_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: if (acc) begin
          rx_ready <= 1'b0;
          if (rx_data == csum) state <= S_DONE;
          else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          rx_ready  <= 1'b0;
          load_done <= 1'b1;
          core_rst  <= 1'b0;
        end
        S_ERR: begin
          rx_ready <= 1'b0;
          load_err <= 1'b1;
          core_rst <= 1'b1;
        end
        default: begin
          state    <= S_ERR;
          rx_ready <= 1'b0;
          load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, 2-word loads with/without gaps, length overflow,
// checksum (when enabled), mid-frame reset and a full 1024-word image.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready, imem_we, core_rst, load_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int n_assert = 0, n_fail = 0, cyc = 0, late = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  xsum;

  imem_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // write monitor; a strobe once done or while the core runs is a protocol violation
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
      if (load_done || !core_rst) late++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      chk("send_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(negedge clk);
      xsum ^= b;
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wa.delete(); wd.delete(); late = 0;
  endtask

  task automatic send_hdr(input logic [15:0] len);
    send(len[15:8], 0);
    send(len[7:0], 0);
    xsum = 8'h00;
  endtask

  task automatic send_frame2(input int maxgap, input int nbytes);
    logic [7:0] f[10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < nbytes; i++) send(f[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nbytes == 10) send(8'h2A, maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
`endif
  endtask

  task automatic check_frame2(input string tag);
    chk({tag, "_nwr"},   32'(wa.size()), 32'd2);
    chk({tag, "_a0"},    qget(wa, 0), 32'd0);
    chk({tag, "_d0"},    qget(wd, 0), 32'hDEADBEEF);
    chk({tag, "_a1"},    qget(wa, 1), 32'd1);
    chk({tag, "_d1"},    qget(wd, 1), 32'h12345678);
    chk({tag, "_words"}, 32'(words_loaded), 32'd2);
    chk({tag, "_done"},  32'(load_done), 32'd1);
    chk({tag, "_crst"},  32'(core_rst), 32'd0);
    chk({tag, "_err"},   32'(load_err), 32'd0);
    chk({tag, "_rdy"},   32'(rx_ready), 32'd0);
    chk({tag, "_late"},  32'(late), 32'd0);
  endtask

  initial begin
    int c0, bad;
    xsum = 8'h00;

    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_crst", 32'(core_rst), 32'd1);
    chk("rst_rdy",  32'(rx_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rdy",   32'(rx_ready), 32'd1);
    chk("post_we",    32'(imem_we), 32'd0);
    chk("post_addr",  32'(imem_addr), 32'd0);
    chk("post_wdata", imem_wdata, 32'd0);
    chk("post_crst",  32'(core_rst), 32'd1);
    chk("post_done",  32'(load_done), 32'd0);
    chk("post_err",   32'(load_err), 32'd0);
    chk("post_words", 32'(words_loaded), 32'd0);

    // 2. back-to-back frame: one byte per cycle
    c0 = cyc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_frame2(0, 10);
    chk("b2b_cycles", 32'(cyc - c0), 32'd11);
`else
    send_frame2(0, 10);
    chk("b2b_cycles", 32'(cyc - c0), 32'd10);
`endif
    idle(5);
    check_frame2("b2b");

    // 3. random gaps
    do_reset();
    send_frame2(5, 10);
    idle(5);
    check_frame2("gap");

    // 4. length overflow 1025
    do_reset();
    send(8'h04, 0);
    send(8'h01, 0);
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_rdy", 32'(rx_ready), 32'd0);
    idle(5);
    chk("ovf_nwr",  32'(wa.size()), 32'd0);
    chk("ovf_crst", 32'(core_rst), 32'd1);
    chk("ovf_done", 32'(load_done), 32'd0);

    // 5. zero-length image and checksum handling
    do_reset();
    send_hdr(16'h0000);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    idle(4);
    chk("len0_done",  32'(load_done), 32'd1);
    chk("len0_words", 32'(words_loaded), 32'd0);
    chk("len0_nwr",   32'(wa.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send_hdr(16'h0001);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h04, 0);
    idle(4);
    chk("cs_ok_done", 32'(load_done), 32'd1);
    chk("cs_ok_err",  32'(load_err), 32'd0);
    chk("cs_ok_d0",   qget(wd, 0), 32'h01020304);
    do_reset();
    send_hdr(16'h0001);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0);
    idle(4);
    chk("cs_bad_err",  32'(load_err), 32'd1);
    chk("cs_bad_crst", 32'(core_rst), 32'd1);
    chk("cs_bad_done", 32'(load_done), 32'd0);
`endif

    // 6. reset mid-frame, then resend
    do_reset();
    send_frame2(0, 6);
    do_reset();
    chk("mid_rdy",   32'(rx_ready), 32'd1);
    chk("mid_words", 32'(words_loaded), 32'd0);
    chk("mid_addr",  32'(imem_addr), 32'd0);
    send_frame2(0, 10);
    idle(5);
    check_frame2("mid");

    // 7. full-capacity image of 1024 words
    do_reset();
    send_hdr(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'hA500_0000 | 32'(i);
      send(w[31:24], 0); send(w[23:16], 0); send(w[15:8], 0); send(w[7:0], 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xsum, 0);
`endif
    idle(5);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 32'(i) || wd[i] !== (32'hA500_0000 | 32'(i))) bad++;
    chk("cap_nwr",   32'(wa.size()), 32'd1024);
    chk("cap_bad",   32'(bad), 32'd0);
    chk("cap_last",  qget(wa, 1023), 32'd1023);
    chk("cap_words", 32'(words_loaded), 32'd1024);
    chk("cap_done",  32'(load_done), 32'd1);
    chk("cap_err",   32'(load_err), 32'd0);
    chk("cap_late",  32'(late), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
